// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c front-end: conditioner FSM encoding and the
// level an idle (released) bus line floats to.
package i2c_pkg;

    localparam logic [1:0] ST_UNARMED = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_BUSY    = 2'd2;

    localparam logic BUS_IDLE = 1'b1;

endpackage

// File: rtl/i2c_glitch_filter.sv
// One bus line: 2-flop synchroniser, stability filter and a one-cycle delayed
// copy of the filtered level for edge detection.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic level_d,
    output logic idle_high
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync_1;
    logic          sync_2;
    logic          primed;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1  <= BUS_IDLE;
            sync_2  <= BUS_IDLE;
            primed  <= 1'b0;
            level   <= BUS_IDLE;
            level_d <= BUS_IDLE;
            cnt     <= '0;
        end else begin
            sync_1  <= raw;
            sync_2  <= sync_1;
            primed  <= 1'b1;
            level_d <= level;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Reset values in the synchroniser are not real pad samples, so a line only
    // counts as idle-high once sync_1 holds a genuine sample and the whole path agrees.
    assign idle_high = primed && sync_1 && sync_2 && level;

endmodule

// File: rtl/i2c_line_conditioner.sv
// Conditions raw SCL/SDA pads for the i2c slave: filtered levels, SCL edge
// pulses, START/STOP detection, bus-busy tracking and SCL-stuck-low timeout.
module i2c_line_conditioner
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN     = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_p,
    output logic stop_p,
    output logic busy,
    output logic timeout
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    logic          scl_f_d;
    logic          sda_f_d;
    logic          scl_idle;
    logic          sda_idle;
    logic [1:0]    state;
    logic [TW-1:0] low_cnt;
    logic          start_cand;
    logic          stop_cand;
    logic          to_hit;

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk       (clk),
        .reset     (reset),
        .raw       (scl_i),
        .level     (scl_f),
        .level_d   (scl_f_d),
        .idle_high (scl_idle)
    );

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk       (clk),
        .reset     (reset),
        .raw       (sda_i),
        .level     (sda_f),
        .level_d   (sda_f_d),
        .idle_high (sda_idle)
    );

    assign scl_rise = scl_f & ~scl_f_d;
    assign scl_fall = ~scl_f & scl_f_d;

    // SCL must be high on both sides of the SDA change; a simultaneous SCL
    // change breaks scl_f & scl_f_d and suppresses the condition.
    assign start_cand = scl_f & scl_f_d & ~sda_f & sda_f_d;
    assign stop_cand  = scl_f & scl_f_d & sda_f & ~sda_f_d;

    assign start_p = start_cand && (state != ST_UNARMED);
    assign stop_p  = stop_cand && (state != ST_UNARMED);
    assign to_hit  = (TIMEOUT_CYCLES > 0) && (state == ST_BUSY) && !scl_f && (low_cnt == TO_LAST);
    assign timeout = to_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_UNARMED;
            busy    <= 1'b0;
            low_cnt <= '0;
        end else begin
            if ((state != ST_BUSY) || scl_f || to_hit) begin
                low_cnt <= '0;
            end else if (low_cnt != '1) begin
                low_cnt <= low_cnt + TW'(1);
            end

            case (state)
                ST_UNARMED: begin
                    if (scl_idle && sda_idle) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (start_cand) begin
                        state <= ST_BUSY;
                        busy  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (to_hit) begin
                        state <= ST_UNARMED;
                        busy  <= 1'b0;
                    end else if (stop_cand) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_UNARMED;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Scoreboard bench: a cycle-level behavioural model predicts every output
// vector; a monitor compares the DUT against it half a cycle after each edge.
`timescale 1ns/1ps
module tb_i2c_line_conditioner;

    localparam int FL = 3;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic reset;
    logic scl_i, sda_i;
    logic scl_f, sda_f, scl_rise, scl_fall, start_p, stop_p, busy, timeout;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int rise_n, fall_n, start_n, stop_n, to_n, sda_low_n;

    i2c_line_conditioner #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_f    (scl_f),
        .sda_f    (sda_f),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_p  (start_p),
        .stop_p   (stop_p),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #1 clk = ~clk;

    // Reference model state. hist[0] is the raw level captured at the previous
    // edge, hist[1] the one before, and so on.
    logic [7:0] exp_q[$];
    bit scl_hist[$];
    bit sda_hist[$];
    bit m_scl, m_sda, m_armed, m_xfer, p_start, p_stop, p_to;
    int since_rst, low_run;

    // A filtered line takes the opposite level once the synchronised samples
    // seen at the last FL edges all disagreed with it.
    function automatic bit will_flip(input bit h[$], input bit f);
        for (int k = 1; k <= FL; k++)
            if (h[k] == f) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit ns, nd, st, sp, to;
        if (!reset) begin
            scl_hist.delete();
            sda_hist.delete();
            for (int k = 0; k < FL + 2; k++) begin
                scl_hist.push_back(1'b1);
                sda_hist.push_back(1'b1);
            end
            since_rst = 0; low_run = 0;
            m_scl = 1'b1; m_sda = 1'b1; m_armed = 1'b0; m_xfer = 1'b0;
            p_start = 1'b0; p_stop = 1'b0; p_to = 1'b0;
            exp_q.push_back(8'b1100_0000);
        end else begin
            since_rst++;
            if (p_to) begin
                m_xfer = 1'b0; m_armed = 1'b0;
            end else if (!m_armed) begin
                m_armed = m_scl && m_sda && (since_rst >= 2) &&
                          scl_hist[0] && scl_hist[1] && sda_hist[0] && sda_hist[1];
            end else if (p_start) begin
                m_xfer = 1'b1;
            end else if (p_stop) begin
                m_xfer = 1'b0;
            end
            ns = will_flip(scl_hist, m_scl) ? ~m_scl : m_scl;
            nd = will_flip(sda_hist, m_sda) ? ~m_sda : m_sda;
            st = m_armed && ns && m_scl && !nd && m_sda;
            sp = m_armed && ns && m_scl && nd && !m_sda;
            if (m_xfer && !ns) low_run++;
            else low_run = 0;
            to = (TO > 0) && (low_run == TO);
            if (to) low_run = 0;
            exp_q.push_back({ns, nd, ns & ~m_scl, ~ns & m_scl, st, sp, m_xfer, to});
            m_scl = ns; m_sda = nd; p_start = st; p_stop = sp; p_to = to;
            scl_hist.push_front(scl_i); void'(scl_hist.pop_back());
            sda_hist.push_front(sda_i); void'(sda_hist.pop_back());
        end
    end

    always @(posedge clk) begin
        logic [7:0] exp_v, act_v;
        #0.5;
        cyc++;
        act_v = {scl_f, sda_f, scl_rise, scl_fall, start_p, stop_p, busy, timeout};
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_underflow cycle %0d: dut=%b, no model entry", cyc, act_v);
        end else begin
            exp_v = exp_q.pop_front();
            if (act_v !== exp_v) begin
                fails++;
                $display("[TB] FAIL scoreboard cycle %0d {scl_f,sda_f,rise,fall,start,stop,busy,timeout}: dut=%b model=%b",
                         cyc, act_v, exp_v);
            end
        end
        if (scl_rise) rise_n++;
        if (scl_fall) fall_n++;
        if (start_p) start_n++;
        if (stop_p) stop_n++;
        if (timeout) to_n++;
        if (!sda_f) sda_low_n++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        rise_n = 0; fall_n = 0; start_n = 0; stop_n = 0; to_n = 0; sda_low_n = 0;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0; scl_i = 1'b1; sda_i = 1'b1;
        clear_counts();
        tick(3);
        check_int("reset_busy", busy, 0);
        check_int("reset_scl_f", scl_f, 1);
        reset = 1'b1;
        tick(10);

        // SCL step reaches scl_f on the fifth edge after it is first sampled
        scl_i = 1'b0;
        repeat (4) @(posedge clk);
        #0.5 check_int("scl_f_held_4_edges", scl_f, 1);
        @(posedge clk);
        #0.5 check_int("scl_f_fell_edge5", scl_f, 0);
        check_int("scl_fall_pulse", scl_fall, 1);
        @(posedge clk);
        #0.5 check_int("scl_fall_one_cycle", scl_fall, 0);
        tick(2);
        scl_i = 1'b1;
        tick(10);

        clear_counts();
        sda_i = 1'b0; tick(2); sda_i = 1'b1;
        tick(10);
        check_int("glitch_sda_low_cycles", sda_low_n, 0);
        check_int("glitch_start", start_n, 0);
        check_int("glitch_busy", busy, 0);

        clear_counts();
        sda_i = 1'b0;
        tick(10);
        check_int("start_count", start_n, 1);
        check_int("busy_after_start", busy, 1);

        clear_counts();
        for (int i = 0; i < 8; i++) begin
            scl_i = 1'b0; tick(3);
            sda_i = (i == 7) ? 1'b0 : 1'(($urandom_range(0, 1)));
            tick(3);
            scl_i = 1'b1; tick(6);
        end
        tick(6);
        check_int("byte_rises", rise_n, 8);
        check_int("byte_falls", fall_n, 8);
        check_int("byte_start", start_n, 0);
        check_int("byte_stop", stop_n, 0);

        clear_counts();
        sda_i = 1'b1;
        tick(10);
        check_int("stop_count", stop_n, 1);
        check_int("busy_after_stop", busy, 0);

        sda_i = 1'b0; tick(10);
        scl_i = 1'b0; tick(4); sda_i = 1'b1; tick(4); scl_i = 1'b1; tick(8);
        clear_counts();
        sda_i = 1'b0;
        tick(10);
        check_int("rep_start_count", start_n, 1);
        check_int("rep_start_busy", busy, 1);

        clear_counts();
        scl_i = 1'b0;
        tick(30);
        check_int("timeout_count", to_n, 1);
        check_int("busy_after_timeout", busy, 0);

        clear_counts();
        scl_i = 1'b1; tick(10);
        sda_i = 1'b1; tick(10);
        check_int("unarmed_start", start_n, 0);
        check_int("unarmed_stop", stop_n, 0);
        sda_i = 1'b0; tick(10);
        check_int("rearmed_start", start_n, 1);
        sda_i = 1'b1; tick(10);

        @(negedge clk) reset = 1'b0;
        sda_i = 1'b0; scl_i = 1'b1;
        tick(3);
        clear_counts();
        reset = 1'b1;
        tick(15);
        check_int("sda_low_release_start", start_n, 0);
        sda_i = 1'b1; tick(10);
        sda_i = 1'b0; tick(10);
        check_int("after_release_start", start_n, 1);
        sda_i = 1'b1; tick(10);

        clear_counts();
        scl_i = 1'b0; sda_i = 1'b0; tick(10);
        scl_i = 1'b1; sda_i = 1'b1; tick(10);
        check_int("simul_start", start_n, 0);
        check_int("simul_stop", stop_n, 0);
        check_int("simul_fall", fall_n, 1);
        check_int("simul_rise", rise_n, 1);

        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                reset = 1'b0; tick(2); reset = 1'b1;
            end
            if ($urandom_range(0, 1) == 1) scl_i = ~scl_i;
            if ($urandom_range(0, 2) == 0) sda_i = ~sda_i;
            tick(($urandom_range(0, 9) == 0) ? 26 : int'($urandom_range(1, 6)));
        end
        scl_i = 1'b1; sda_i = 1'b1;
        tick(12);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/i2c_line_conditioner.md
Name: i2c_line_conditioner

Overview:
- Front-end stage directly upstream of the i2c slave; all raw SCL/SDA pad inputs pass through it.
- Synchronises both lines to clk and rejects glitches with a per-line stability filter.
- Produces clean levels, single-cycle SCL edge pulses and START/STOP condition pulses for the slave FSM.
- Tracks bus-busy state and flags an SCL-stuck-low timeout.

Parameters:
- FILTER_LEN, 3, consecutive clk cycles a synchronised line must differ from its filtered level before the filtered level flips (>=1).
- TIMEOUT_CYCLES, 1000, consecutive cycles of filtered SCL low while busy that raise timeout; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- scl_i  in  1  raw SCL pad level
- sda_i  in  1  raw SDA pad level
- scl_f  out  1  filtered SCL level
- sda_f  out  1  filtered SDA level
- scl_rise  out  1  1-cycle pulse, filtered SCL 0->1
- scl_fall  out  1  1-cycle pulse, filtered SCL 1->0
- start_p  out  1  1-cycle pulse, START or repeated START detected
- stop_p  out  1  1-cycle pulse, STOP detected
- busy  out  1  bus owned between START and STOP/timeout
- timeout  out  1  1-cycle pulse, SCL held low >= TIMEOUT_CYCLES while busy

Behaviour:
- Reset (reset=0, async): sync flops=1, scl_f=sda_f=1, delayed copies=1, filter counters=0, all pulses=0, busy=0, FSM=UNARMED.
- Sync: 2-flop synchroniser per line, giving s_scl and s_sda.
- Filter, per line:
  - While s != f, the counter increments; when s == f, the counter clears to 0.
  - When the counter == FILTER_LEN-1 and s != f, then f <= s and the counter clears.
  - A raw step appears on scl_f/sda_f exactly 2+FILTER_LEN clk edges after it is first sampled.
  - A pulse of fewer than FILTER_LEN sync cycles never reaches f.
- Edges: f_d is f registered one cycle.
  - scl_rise = scl_f & ~scl_f_d; scl_fall = ~scl_f & scl_f_d.
  - Edge pulses are asserted in the cycle after f changes and last exactly 1 cycle.
- Condition detect: requires scl_f=1 and scl_f_d=1 (SCL stable high across the SDA change).
  - SDA 1->0 gives a START candidate.
  - SDA 0->1 gives a STOP candidate.
  - If SCL and SDA filtered levels change in the same cycle, no START/STOP is generated; only the SCL edge pulse fires.
- FSM:
  - UNARMED: all START/STOP candidates are ignored. Go to IDLE once scl_f=1 and sda_f=1 in the same cycle. This prevents a false START when SDA is held low at reset release.
  - IDLE: START candidate -> start_p=1, busy<=1, go to BUSY. STOP candidate -> stop_p=1, stay in IDLE.
  - BUSY: START candidate -> start_p=1 (repeated START), stay in BUSY. STOP candidate -> stop_p=1, busy<=0, go to IDLE. Timeout -> timeout=1, busy<=0, go to UNARMED.
  - start_p/stop_p are asserted in the same cycle as the corresponding SDA edge pulse timing (the cycle after sda_f changes).
  - busy changes in the cycle after the corresponding pulse.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Counts while state==BUSY and scl_f==0; clears when scl_f==1 or state!=BUSY.
  - When count reaches TIMEOUT_CYCLES-1 with SCL still low, timeout fires and the counter clears.
  - No timeout when TIMEOUT_CYCLES==0; counter saturates and never wraps.
- Reset mid-transfer: immediate return to reset values. After release, the FSM rearms only after both filtered lines are observed high.

Decomposition:
- Shared package i2c_pkg: FSM state encoding (UNARMED/IDLE/BUSY) and the bus idle level constant (1'b1).
- Sub-module i2c_glitch_filter (param FILTER_LEN): synchroniser + stability filter + f_d register for one line, instantiated twice; edge pulses come from its f/f_d outputs.

Test Plan (clk period 2 ns, FILTER_LEN=3, TIMEOUT_CYCLES=20):
- Reset with both lines high, release, step scl_i 1->0 -> scl_f falls exactly 5 clk edges later; scl_fall high for exactly 1 cycle.
- With SCL held high, drive an SDA low glitch of 2 clk cycles -> sda_f stays 1, no start_p, busy stays 0.
- With SCL high, SDA 1->0 -> start_p 1 cycle, busy=1 next cycle. Then send 8 SCL clocks -> 8 scl_rise/8 scl_fall, no start/stop. Then, with SCL high, SDA 0->1 -> stop_p 1 cycle, busy=0.
- While busy, SDA 1->0 with SCL high -> second start_p, busy remains 1, state stays BUSY.
- While busy, hold SCL low 20+ cycles -> timeout pulse after 20 cycles of scl_f=0, busy=0. Then SDA falls while SCL high (before both lines are seen high) -> no start_p.
- Release reset with sda_i=0, scl_i=1 -> no start_p. Raise SDA, then drop it -> exactly one start_p on the drop.
- Change scl_i and sda_i in the same sample -> scl edge pulse only, no start_p/stop_p.
